layer2_out_reader: RTL and testbench

Drains the ping-pong output SRAM pair written by the second BNN layer and streams its contents to the third-layer datapath. When the layer-2 writer flags a bank full, it reads the bank's 64-bit words in address order and splits each word into four 16-bit beats on a valid/ready stream. After the last word it returns the bank with a one-cycle empty pulse, so the writer can refill it while the other bank is drained.

---
 rtl/layer2_out_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_layer2_out_reader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_out_reader.sv
// layer2_out_reader
// Drains the layer-2 ping-pong output SRAMs in strict bank order 1,2,1,2,...
// Each 64-bit word is read once, held locally and streamed as four 16-bit
// beats (low half-word first) on a valid/ready interface. When the last
// word of a bank has been accepted, a one-cycle empty pulse hands the bank
// back to the layer-2 writer. Every output comes straight from a flop.
module layer2_out_reader #(
  parameter int NEXT_ADDR = 9,
  parameter int DEPTH     = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 next_sram_full1,
  input  logic                 next_sram_full2,
  input  logic [63:0]          next_data,
  output logic                 next_en1,
  output logic                 next_rd1,
  output logic                 next_en2,
  output logic                 next_rd2,
  output logic [NEXT_ADDR-1:0] next_addr,
  output logic                 next_sram_empty1,
  output logic                 next_sram_empty2,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  typedef enum logic {
    BANK1,
    BANK2
  } bank_t;

  localparam logic [NEXT_ADDR-1:0] LAST_WORD = NEXT_ADDR'(DEPTH - 1);

  // Control state
  state_t                state_q, state_d;
  bank_t                 bank_q, bank_d;
  logic [NEXT_ADDR-1:0]  cnt_q, cnt_d;
  logic [1:0]            beat_q, beat_d;

  // Datapath holding register for the word being streamed
  logic [63:0]           word_q, word_d;

  // Registered outputs
  logic                  en1_q, en1_d;
  logic                  rd1_q, rd1_d;
  logic                  en2_q, en2_d;
  logic                  rd2_q, rd2_d;
  logic [NEXT_ADDR-1:0]  addr_q, addr_d;
  logic                  empty1_q, empty1_d;
  logic                  empty2_q, empty2_d;
  logic [15:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  // Helpers
  logic                  cur_full;
  logic                  rd_go;
  logic                  handshake;
  logic [1:0]            beat_nxt;
  logic [NEXT_ADDR-1:0]  cnt_inc;

  // Only the bank whose turn it is can start a drain; the other flag is ignored.
  assign cur_full  = (bank_q == BANK1) ? next_sram_full1 : next_sram_full2;
  assign handshake = valid_q && out_ready;
  assign beat_nxt  = beat_q + 2'd1;
  assign cnt_inc   = cnt_q + 1'b1;

  // Next-state and next-output logic for the drain sequencer.
  always_comb begin
    // NOTE: every value written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    bank_d   = bank_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    word_d   = word_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    en1_d    = 1'b1;
    rd1_d    = 1'b1;
    en2_d    = 1'b1;
    rd2_d    = 1'b1;
    empty1_d = 1'b0;
    empty2_d = 1'b0;
    rd_go    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cur_full) begin
          state_d = S_READ;
          cnt_d   = '0;
          addr_d  = '0;
          rd_go   = 1'b1;
        end
      end

      // Strobes are low for exactly this one cycle; the SRAM returns data
      // during CAPT.
      S_READ: begin
        state_d = S_CAPT;
      end

      S_CAPT: begin
        state_d = S_SEND;
        word_d  = next_data;
        data_d  = next_data[15:0];
        valid_d = 1'b1;
        beat_d  = 2'd0;
      end

      // One beat per accepted handshake; valid drops with the last beat so
      // there is never a beat on the cycle the next word is being fetched.
      S_SEND: begin
        if (handshake) begin
          if (beat_q == 2'd3) begin
            valid_d = 1'b0;
            if (cnt_q == LAST_WORD) begin
              state_d = S_DONE;
            end else begin
              state_d = S_READ;
              cnt_d   = cnt_inc;
              addr_d  = cnt_inc;
              rd_go   = 1'b1;
            end
          end else begin
            beat_d = beat_nxt;
            data_d = word_q[{beat_nxt, 4'b0000} +: 16];
          end
        end
      end

      // Hand the bank back and move on to the other one.
      S_DONE: begin
        state_d = S_IDLE;
        bank_d  = (bank_q == BANK1) ? BANK2 : BANK1;
        cnt_d   = '0;
        if (bank_q == BANK1) begin
          empty1_d = 1'b1;
        end else begin
          empty2_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Chip select and read enable of the current bank only; the address is
    // shared, so the idle bank must stay deselected.
    if (rd_go) begin
      if (bank_q == BANK1) begin
        en1_d = 1'b0;
        rd1_d = 1'b0;
      end else begin
        en2_d = 1'b0;
        rd2_d = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state, bank pointer and word/beat counters.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst) begin
      state_q <= S_IDLE;
      bank_q  <= BANK1;
      cnt_q   <= '0;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  // Holding register for the word currently being split into beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Output registers; a reset mid-frame drops straight back to idle values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en1_q    <= 1'b1;
      rd1_q    <= 1'b1;
      en2_q    <= 1'b1;
      rd2_q    <= 1'b1;
      addr_q   <= '0;
      empty1_q <= 1'b0;
      empty2_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      en1_q    <= en1_d;
      rd1_q    <= rd1_d;
      en2_q    <= en2_d;
      rd2_q    <= rd2_d;
      addr_q   <= addr_d;
      empty1_q <= empty1_d;
      empty2_q <= empty2_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign next_en1         = en1_q;
  assign next_rd1         = rd1_q;
  assign next_en2         = en2_q;
  assign next_rd2         = rd2_q;
  assign next_addr        = addr_q;
  assign next_sram_empty1 = empty1_q;
  assign next_sram_empty2 = empty2_q;
  assign out_data         = data_q;
  assign out_valid        = valid_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_layer2_out_reader.sv
// Bench for layer2_out_reader: a DEPTH=4 instance for the functional
// scenarios and a DEPTH=512 instance for the full address range.
module tb_layer2_out_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DEPTH = 4 instance
  logic        full1, full2, ready;
  logic [63:0] ndata;
  logic        en1, rd1, en2, rd2;
  logic [8:0]  addr;
  logic        empty1, empty2;
  logic [15:0] odata;
  logic        ovalid, busy;

  // DEPTH = 512 instance
  logic        full1_w, full2_w, ready_w;
  logic [63:0] ndata_w;
  logic        en1_w, rd1_w, en2_w, rd2_w;
  logic [8:0]  addr_w;
  logic        empty1_w, empty2_w;
  logic [15:0] odata_w;
  logic        ovalid_w, busy_w;

  int n_cmp = 0;
  int n_err = 0;

  layer2_out_reader #(.NEXT_ADDR(9), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .next_sram_full1(full1), .next_sram_full2(full2), .next_data(ndata),
    .next_en1(en1), .next_rd1(rd1), .next_en2(en2), .next_rd2(rd2),
    .next_addr(addr), .next_sram_empty1(empty1), .next_sram_empty2(empty2),
    .out_data(odata), .out_valid(ovalid), .out_ready(ready), .busy(busy)
  );

  layer2_out_reader #(.NEXT_ADDR(9), .DEPTH(512)) u_wrap (
    .clk(clk), .rst(rst),
    .next_sram_full1(full1_w), .next_sram_full2(full2_w), .next_data(ndata_w),
    .next_en1(en1_w), .next_rd1(rd1_w), .next_en2(en2_w), .next_rd2(rd2_w),
    .next_addr(addr_w), .next_sram_empty1(empty1_w), .next_sram_empty2(empty2_w),
    .out_data(odata_w), .out_valid(ovalid_w), .out_ready(ready_w), .busy(busy_w)
  );

  // Bank contents of the small instance: bank 1 word n is n in every
  // half-word plus n<<4; bank 2 flips the top bit of every half-word.
  function automatic logic [63:0] w_main(input int b, input int n);
    logic [15:0] l;
    logic [63:0] w;
    l = 16'(n);
    w = {l, l, l, l} + 64'(n << 4);
    if (b == 2) w = w ^ 64'h8000_8000_8000_8000;
    return w;
  endfunction

  function automatic logic [63:0] w_wrap(input int b, input int n);
    logic [15:0] l;
    l = 16'(n);
    return {l, ~l, 8'(b), 8'h5A, l + 16'h1000};
  endfunction

  // SRAM models: one-cycle read latency, data from whichever bank was strobed.
  always @(posedge clk) begin
    if (!en1 && !rd1)      ndata <= w_main(1, int'(addr));
    else if (!en2 && !rd2) ndata <= w_main(2, int'(addr));
  end

  always @(posedge clk) begin
    if (!en1_w && !rd1_w)      ndata_w <= w_wrap(1, int'(addr_w));
    else if (!en2_w && !rd2_w) ndata_w <= w_wrap(2, int'(addr_w));
  end

  // Monitor of the small instance, sampled on the falling edge.
  int          cyc = 0;
  logic [8:0]  rd1_addr[$];
  int          rd1_cyc[$];
  int          rd2_cyc[$];
  int          empty1_cyc[$];
  int          empty2_cyc[$];
  int          valid_cyc[$];
  logic [15:0] beats[$];
  int          long_strobe = 0;
  int          overlap = 0;
  int          stall_err = 0;
  bit          s1, s2, prev_s1, prev_s2, prev_valid, prev_stall;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      s1 = !en1 && !rd1;
      s2 = !en2 && !rd2;
      if (s1) begin rd1_addr.push_back(addr); rd1_cyc.push_back(cyc); end
      if (s2) rd2_cyc.push_back(cyc);
      if ((s1 && prev_s1) || (s2 && prev_s2)) long_strobe++;
      if ((!en1 || !rd1) && (!en2 || !rd2)) overlap++;
      if (empty1) empty1_cyc.push_back(cyc);
      if (empty2) empty2_cyc.push_back(cyc);
      if (ovalid && !prev_valid) valid_cyc.push_back(cyc);
      if (prev_stall && (ovalid !== 1'b1 || odata !== prev_data)) stall_err++;
      if (ovalid && ready) beats.push_back(odata);
      prev_s1    = s1;
      prev_s2    = s2;
      prev_valid = ovalid;
      prev_stall = ovalid && !ready;
      prev_data  = odata;
    end else begin
      prev_s1    = 1'b0;
      prev_s2    = 1'b0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end
    cyc++;
  end

  // Monitor of the DEPTH=512 instance.
  int          w_rd1 = 0, w_rd2 = 0, w_addr_err = 0, w_overlap = 0;
  int          w_e1 = 0, w_e2 = 0, w_beats = 0, w_beat_err = 0;
  logic [8:0]  w_last1 = '0, w_first2 = 9'h1AA, w_addr_e1 = '0;
  int          w_idx;
  logic [63:0] w_word;

  always @(negedge clk) begin
    if (rst) begin
      if (!en1_w && !rd1_w) begin
        if (addr_w !== 9'(w_rd1 % 512)) w_addr_err++;
        w_last1 = addr_w;
        w_rd1++;
      end
      if (!en2_w && !rd2_w) begin
        if (w_rd2 == 0) w_first2 = addr_w;
        if (addr_w !== 9'(w_rd2 % 512)) w_addr_err++;
        w_rd2++;
      end
      if ((!en1_w || !rd1_w) && (!en2_w || !rd2_w)) w_overlap++;
      if (empty1_w) begin w_e1++; w_addr_e1 = addr_w; end
      if (empty2_w) w_e2++;
      if (ovalid_w && ready_w) begin
        w_idx  = w_beats;
        w_word = w_wrap((w_idx < 2048) ? 1 : 2, (w_idx / 4) % 512);
        if (odata_w !== w_word[(w_idx % 4) * 16 +: 16]) w_beat_err++;
        w_beats++;
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    full1 = 1'b0;
    full2 = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int bb, br;
    bit hit;
    n_cmp++; if ({en1, rd1, en2, rd2} !== 4'hF) begin n_err++; $display("FAIL rst_strobes: got %b expected 1111", {en1, rd1, en2, rd2}); end
    n_cmp++; if (addr !== 9'd0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", addr); end
    n_cmp++; if ({empty1, empty2} !== 2'b00) begin n_err++; $display("FAIL rst_empty: got %b expected 00", {empty1, empty2}); end
    n_cmp++; if ({ovalid, busy, odata} !== 18'd0) begin n_err++; $display("FAIL rst_stream: got valid=%b busy=%b data=%h expected 0/0/0000", ovalid, busy, odata); end

    full1 = 1'b1;
    bb    = beats.size();
    hit   = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      if (ovalid && beats.size() >= bb + 5) hit = 1'b1;
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL reach_send: got %0d beats expected 5 within bound", beats.size() - bb); end

    rst   = 1'b0;
    full1 = 1'b0;
    full2 = 1'b1;
    #1;
    n_cmp++; if ({en1, rd1, en2, rd2} !== 4'hF) begin n_err++; $display("FAIL midrst_strobes: got %b expected 1111", {en1, rd1, en2, rd2}); end
    n_cmp++; if (addr !== 9'd0) begin n_err++; $display("FAIL midrst_addr: got %h expected 0", addr); end
    n_cmp++; if (odata !== 16'h0000) begin n_err++; $display("FAIL midrst_data: got %h expected 0000", odata); end
    n_cmp++; if ({ovalid, busy, empty1, empty2} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b expected 0000", {ovalid, busy, empty1, empty2}); end

    tick();
    tick();
    br  = rd1_cyc.size() + rd2_cyc.size();
    rst = 1'b1;
    repeat (20) tick();
    n_cmp++; if (rd1_cyc.size() + rd2_cyc.size() - br !== 0) begin n_err++; $display("FAIL full2_ignored_reads: got %0d expected 0", rd1_cyc.size() + rd2_cyc.size() - br); end
    n_cmp++; if ({busy, en1, rd1, en2, rd2} !== 5'b01111) begin n_err++; $display("FAIL full2_ignored_idle: got %b expected 01111", {busy, en1, rd1, en2, rd2}); end
    full2 = 1'b0;
  endtask

  task automatic test_single_frame();
    int bb, br1, br2, be1, bl, bv, bad;
    bit done;
    logic [63:0] w;
    logic [15:0] exp;
    apply_reset();
    bb = beats.size(); br1 = rd1_cyc.size(); br2 = rd2_cyc.size();
    be1 = empty1_cyc.size(); bl = long_strobe; bv = valid_cyc.size();
    full1 = 1'b1;
    tick();
    n_cmp++; if ({busy, en1, rd1, addr} !== {3'b100, 9'd0}) begin n_err++; $display("FAIL first_read: got busy=%b en1=%b rd1=%b addr=%h expected 1/0/0/000", busy, en1, rd1, addr); end
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (empty1_cyc.size() > be1) done = 1'b1;
    end
    full1 = 1'b0;
    repeat (5) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sf_empty_seen: got %b expected 1", done); end
    n_cmp++; if (beats.size() - bb !== 16) begin n_err++; $display("FAIL sf_beat_count: got %0d expected 16", beats.size() - bb); end
    if (beats.size() - bb >= 16) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        w = w_main(1, i / 4);
        exp = w[(i % 4) * 16 +: 16];
        if (beats[bb + i] !== exp) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL sf_beat_data: got %0d wrong beats expected 0", bad); end
      n_cmp++; if (beats[bb + 4] !== 16'h0011) begin n_err++; $display("FAIL sf_beat4: got %h expected 0011", beats[bb + 4]); end
      n_cmp++; if (beats[bb + 12] !== 16'h0033) begin n_err++; $display("FAIL sf_beat12: got %h expected 0033", beats[bb + 12]); end
      n_cmp++; if (beats[bb + 15] !== 16'h0003) begin n_err++; $display("FAIL sf_beat15: got %h expected 0003", beats[bb + 15]); end
    end
    n_cmp++; if (rd1_cyc.size() - br1 !== 4) begin n_err++; $display("FAIL sf_reads: got %0d expected 4", rd1_cyc.size() - br1); end
    n_cmp++; if (rd2_cyc.size() - br2 !== 0) begin n_err++; $display("FAIL sf_bank2_reads: got %0d expected 0", rd2_cyc.size() - br2); end
    n_cmp++; if (long_strobe - bl !== 0) begin n_err++; $display("FAIL sf_strobe_len: got %0d long strobes expected 0", long_strobe - bl); end
    if (rd1_cyc.size() - br1 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (rd1_addr[br1 + i] !== 9'(i)) begin n_err++; $display("FAIL sf_addr%0d: got %h expected %h", i, rd1_addr[br1 + i], 9'(i)); end
      end
      n_cmp++; if (rd1_cyc[br1 + 1] - rd1_cyc[br1] !== 6) begin n_err++; $display("FAIL sf_word_period: got %0d expected 6", rd1_cyc[br1 + 1] - rd1_cyc[br1]); end
    end
    n_cmp++; if (empty1_cyc.size() - be1 !== 1) begin n_err++; $display("FAIL sf_empty_pulses: got %0d expected 1", empty1_cyc.size() - be1); end
    if (done && rd1_cyc.size() > br1 && valid_cyc.size() > bv) begin
      n_cmp++; if (empty1_cyc[be1] - rd1_cyc[br1] !== 25) begin n_err++; $display("FAIL sf_empty_latency: got %0d expected 25", empty1_cyc[be1] - rd1_cyc[br1]); end
      n_cmp++; if (valid_cyc[bv] - rd1_cyc[br1] !== 2) begin n_err++; $display("FAIL sf_valid_latency: got %0d expected 2", valid_cyc[bv] - rd1_cyc[br1]); end
    end
    n_cmp++; if ({busy, ovalid} !== 2'b00) begin n_err++; $display("FAIL sf_idle_after: got %b expected 00", {busy, ovalid}); end
  endtask

  task automatic test_ping_pong();
    int bb, br1, br2, be1, be2, bo, bad;
    bit done;
    logic [63:0] w;
    logic [15:0] exp;
    apply_reset();
    bb = beats.size(); br1 = rd1_cyc.size(); br2 = rd2_cyc.size();
    be1 = empty1_cyc.size(); be2 = empty2_cyc.size(); bo = overlap;
    full1 = 1'b1;
    full2 = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (empty1_cyc.size() > be1) full1 = 1'b0;
      if (empty2_cyc.size() > be2) done = 1'b1;
    end
    full1 = 1'b0;
    full2 = 1'b0;
    repeat (20) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pp_empty2_seen: got %b expected 1", done); end
    n_cmp++; if (beats.size() - bb !== 32) begin n_err++; $display("FAIL pp_beat_count: got %0d expected 32", beats.size() - bb); end
    if (beats.size() - bb >= 32) begin
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        w = w_main((i < 16) ? 1 : 2, (i / 4) % 4);
        exp = w[(i % 4) * 16 +: 16];
        if (beats[bb + i] !== exp) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pp_beat_data: got %0d wrong beats expected 0", bad); end
      n_cmp++; if (beats[bb + 20] !== 16'h8011) begin n_err++; $display("FAIL pp_bank2_beat: got %h expected 8011", beats[bb + 20]); end
    end
    n_cmp++; if ({rd1_cyc.size() - br1, rd2_cyc.size() - br2} !== {32'd4, 32'd4}) begin n_err++; $display("FAIL pp_reads: got %0d/%0d expected 4/4", rd1_cyc.size() - br1, rd2_cyc.size() - br2); end
    n_cmp++; if (overlap - bo !== 0) begin n_err++; $display("FAIL pp_overlap: got %0d expected 0", overlap - bo); end
    n_cmp++; if ({empty1_cyc.size() - be1, empty2_cyc.size() - be2} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL pp_empties: got %0d/%0d expected 1/1", empty1_cyc.size() - be1, empty2_cyc.size() - be2); end
    if (empty1_cyc.size() > be1 && rd2_cyc.size() > br2 && rd1_cyc.size() >= br1 + 4 && empty2_cyc.size() > be2) begin
      n_cmp++; if (rd2_cyc[br2] - empty1_cyc[be1] !== 1) begin n_err++; $display("FAIL pp_bank2_start: got %0d expected 1", rd2_cyc[br2] - empty1_cyc[be1]); end
      n_cmp++; if (rd1_cyc[br1 + 3] >= rd2_cyc[br2]) begin n_err++; $display("FAIL pp_order: got bank1 last read %0d expected before %0d", rd1_cyc[br1 + 3], rd2_cyc[br2]); end
      n_cmp++; if (empty2_cyc[be2] - rd2_cyc[br2] !== 25) begin n_err++; $display("FAIL pp_empty2_latency: got %0d expected 25", empty2_cyc[be2] - rd2_cyc[br2]); end
    end
  endtask

  task automatic test_backpressure();
    int bb, br1, be1, bl, bs, bad, stall_n;
    bit done;
    logic [63:0] w;
    logic [15:0] exp;
    apply_reset();
    bb = beats.size(); br1 = rd1_cyc.size(); be1 = empty1_cyc.size();
    bl = long_strobe; bs = stall_err;
    stall_n = 0;
    full1 = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      if (empty1_cyc.size() > be1) done = 1'b1;
      if (beats.size() - bb == 2 && stall_n < 10) begin
        ready = 1'b0;
        stall_n++;
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
    end
    ready = 1'b1;
    full1 = 1'b0;
    repeat (5) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_empty_seen: got %b expected 1", done); end
    n_cmp++; if (beats.size() - bb !== 16) begin n_err++; $display("FAIL bp_beat_count: got %0d expected 16", beats.size() - bb); end
    if (beats.size() - bb >= 16) begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        w = w_main(1, i / 4);
        exp = w[(i % 4) * 16 +: 16];
        if (beats[bb + i] !== exp) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_beat_data: got %0d wrong beats expected 0", bad); end
    end
    n_cmp++; if (stall_err - bs !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_err - bs); end
    n_cmp++; if (rd1_cyc.size() - br1 !== 4) begin n_err++; $display("FAIL bp_reads: got %0d expected 4", rd1_cyc.size() - br1); end
    n_cmp++; if (long_strobe - bl !== 0) begin n_err++; $display("FAIL bp_strobe_len: got %0d expected 0", long_strobe - bl); end
  endtask

  task automatic test_full_drop();
    int bb, br1, be1;
    bit done;
    apply_reset();
    bb = beats.size(); br1 = rd1_cyc.size(); be1 = empty1_cyc.size();
    full1 = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (rd1_cyc.size() - br1 >= 2) full1 = 1'b0;
      if (empty1_cyc.size() > be1) done = 1'b1;
    end
    full1 = 1'b0;
    repeat (5) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fd_empty_seen: got %b expected 1", done); end
    n_cmp++; if (rd1_cyc.size() - br1 !== 4) begin n_err++; $display("FAIL fd_reads: got %0d expected 4", rd1_cyc.size() - br1); end
    n_cmp++; if (beats.size() - bb !== 16) begin n_err++; $display("FAIL fd_beat_count: got %0d expected 16", beats.size() - bb); end
    n_cmp++; if (empty1_cyc.size() - be1 !== 1) begin n_err++; $display("FAIL fd_empty_pulses: got %0d expected 1", empty1_cyc.size() - be1); end
  endtask

  task automatic test_wrap();
    bit got1, got2;
    full1_w = 1'b1;
    full2_w = 1'b1;
    got1 = 1'b0;
    for (int i = 0; i < 4000 && !got1; i++) begin
      tick();
      if (w_e1 > 0) got1 = 1'b1;
    end
    full1_w = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < 4000 && !got2; i++) begin
      tick();
      if (w_e2 > 0) got2 = 1'b1;
    end
    full2_w = 1'b0;
    repeat (5) tick();
    n_cmp++; if ({got1, got2} !== 2'b11) begin n_err++; $display("FAIL wr_empties_seen: got %b expected 11", {got1, got2}); end
    n_cmp++; if (w_rd1 !== 512) begin n_err++; $display("FAIL wr_bank1_reads: got %0d expected 512", w_rd1); end
    n_cmp++; if (w_last1 !== 9'h1FF) begin n_err++; $display("FAIL wr_last_addr: got %h expected 1ff", w_last1); end
    n_cmp++; if (w_addr_e1 !== 9'h1FF) begin n_err++; $display("FAIL wr_addr_at_empty: got %h expected 1ff", w_addr_e1); end
    n_cmp++; if (w_first2 !== 9'h000) begin n_err++; $display("FAIL wr_bank2_first_addr: got %h expected 000", w_first2); end
    n_cmp++; if (w_rd2 !== 512) begin n_err++; $display("FAIL wr_bank2_reads: got %0d expected 512", w_rd2); end
    n_cmp++; if (w_addr_err !== 0) begin n_err++; $display("FAIL wr_addr_seq: got %0d bad addresses expected 0", w_addr_err); end
    n_cmp++; if (w_beats !== 4096) begin n_err++; $display("FAIL wr_beat_count: got %0d expected 4096", w_beats); end
    n_cmp++; if (w_beat_err !== 0) begin n_err++; $display("FAIL wr_beat_data: got %0d wrong beats expected 0", w_beat_err); end
    n_cmp++; if ({w_e1, w_e2, w_overlap} !== {32'd1, 32'd1, 32'd0}) begin n_err++; $display("FAIL wr_pulses_overlap: got %0d/%0d/%0d expected 1/1/0", w_e1, w_e2, w_overlap); end
  endtask

  initial begin
    rst     = 1'b0;
    full1   = 1'b0;
    full2   = 1'b0;
    ready   = 1'b1;
    full1_w = 1'b0;
    full2_w = 1'b0;
    ready_w = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    test_reset();
    test_single_frame();
    test_ping_pong();
    test_backpressure();
    test_full_drop();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
